// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// Purpose: 8N1-style UART receiver with a single-byte holding register, frame-error pulse and sticky overrun flag.
// Latency: 2-cycle input synchronizer; o_rx_valid rises one cycle after the mid-stop-bit sample.
// Backpressure: none on the serial line; an unread byte is overwritten by the next good frame and o_overrun is set.
module uart_rx #(
  parameter int clks_per_bit = 104,
  parameter int BITS         = 8
) (
  input  logic            i_wb_clk,
  input  logic            i_wb_rst,
  input  logic            i_rx,
  input  logic            i_rd,
  output logic [BITS-1:0] o_wb_dat,
  output logic            o_rx_valid,
  output logic            o_frame_err,
  output logic            o_overrun,
  output logic            o_busy
);

  localparam int CW = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  localparam int IW = (BITS > 1) ? $clog2(BITS) : 1;

  // Terminal counts: half a bit to centre on the start bit, a full bit thereafter.
  localparam logic [CW-1:0] HALF_LAST = CW'(clks_per_bit / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(clks_per_bit - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [BITS-1:0] shift_q, shift_d;
  logic            rx_meta, rx_s;
  logic            commit;
  logic            ferr_set;

  // Two-flop synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  // FSM state, bit-period counter, bit index and shift register.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic: sample each bit at its centre, commit on a good stop bit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    commit   = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          // A line that is high again at mid-start was only a glitch.
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            commit  = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BREAK: begin
        // Wait out a held-low line so it cannot produce further errors.
        cnt_d = '0;
        idx_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Holding register and status flags; a commit takes priority over a read in the same cycle.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      o_wb_dat    <= '0;
      o_rx_valid  <= 1'b0;
      o_overrun   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_frame_err <= ferr_set;
      if (i_rd && o_rx_valid) begin
        o_rx_valid <= 1'b0;
        o_overrun  <= 1'b0;
      end
      if (commit) begin
        o_wb_dat   <= shift_q;
        o_rx_valid <= 1'b1;
        if (o_rx_valid && !i_rd) o_overrun <= 1'b1;
      end
    end
  end

  assign o_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Purpose: self-checking bench for uart_rx against a byte-level model of the holding register and flags.
// Latency: checks are taken after each frame completes, sampled on the falling clock edge.
// Backpressure: exercises overrun, read/commit collision, frame errors, glitches and baud skew.
module tb_uart_rx;

  localparam int  CPB    = 16;
  localparam int  NB     = 8;
  localparam real BIT_NS = 160.0;

  logic       i_wb_clk = 1'b0;
  logic       i_wb_rst;
  logic       i_rx;
  logic       i_rd;
  logic [7:0] o_wb_dat;
  logic       o_rx_valid;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model of what the consumer should see.
  logic [7:0] exp_dat;
  logic       exp_vld;
  logic       exp_ovr;
  int         exp_ferr  = 0;
  int         ferr_seen = 0;

  uart_rx #(.clks_per_bit(CPB), .BITS(NB)) dut (
    .i_wb_clk   (i_wb_clk),
    .i_wb_rst   (i_wb_rst),
    .i_rx       (i_rx),
    .i_rd       (i_rd),
    .o_wb_dat   (o_wb_dat),
    .o_rx_valid (o_rx_valid),
    .o_frame_err(o_frame_err),
    .o_overrun  (o_overrun),
    .o_busy     (o_busy)
  );

  always #5 i_wb_clk = ~i_wb_clk;

  // Count frame-error pulses; a stuck pulse is counted once per cycle.
  always @(negedge i_wb_clk) if (o_frame_err === 1'b1) ferr_seen++;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_dat = 8'h00;
    exp_vld = 1'b0;
    exp_ovr = 1'b0;
  endtask

  task automatic model_commit(input logic [7:0] b, input logic rd_same);
    if (exp_vld && !rd_same) exp_ovr = 1'b1;
    else if (exp_vld && rd_same) exp_ovr = 1'b0;
    exp_dat = b;
    exp_vld = 1'b1;
  endtask

  task automatic model_rd();
    if (exp_vld) begin
      exp_vld = 1'b0;
      exp_ovr = 1'b0;
    end
  endtask

  task automatic check_state(input string tag);
    @(negedge i_wb_clk);
    chk({tag, "_dat"}, o_wb_dat, exp_dat);
    chk({tag, "_vld"}, o_rx_valid, exp_vld);
    chk({tag, "_ovr"}, o_overrun, exp_ovr);
    chk({tag, "_ferr"}, ferr_seen, exp_ferr);
  endtask

  // Serial frame with arbitrary bit time; the line is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input real bit_ns);
    i_rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < NB; i++) begin
      i_rx = b[i];
      #(bit_ns);
    end
    i_rx = stop_bit;
    #(bit_ns);
  endtask

  task automatic do_rd();
    @(posedge i_wb_clk);
    #1 i_rd = 1'b1;
    @(posedge i_wb_clk);
    #1 i_rd = 1'b0;
    model_rd();
  endtask

  // Clock-aligned frame with i_rd asserted exactly in the commit cycle:
  // start seen 3 edges after the fall, centred 8 later, then 9 bits of 16 -> edge 155.
  task automatic send_sync_rd(input logic [7:0] b);
    @(posedge i_wb_clk);
    #1 i_rx = 1'b0;
    for (int i = 0; i < NB; i++) begin
      repeat (CPB) @(posedge i_wb_clk);
      #1 i_rx = b[i];
    end
    repeat (CPB) @(posedge i_wb_clk);
    #1 i_rx = 1'b1;
    repeat (10) @(posedge i_wb_clk);
    #1 i_rd = 1'b1;
    @(posedge i_wb_clk);
    #1 i_rd = 1'b0;
    repeat (6) @(posedge i_wb_clk);
  endtask

  initial begin
    logic [7:0] b;
    real        pf [7];
    pf = '{0.97, 0.98, 0.99, 1.00, 1.01, 1.02, 1.03};

    i_wb_rst = 1'b1;
    i_rx     = 1'b1;
    i_rd     = 1'b0;
    model_reset();
    repeat (3) @(posedge i_wb_clk);
    check_state("reset");
    chk("reset_busy", o_busy, 1'b0);
    @(posedge i_wb_clk);
    #1 i_wb_rst = 1'b0;
    repeat (4) @(posedge i_wb_clk);

    // Single good frame; valid must still be low before the stop bit centre.
    fork
      send_frame(8'hA5, 1'b1, BIT_NS);
      begin
        #(BIT_NS * 9.25);
        @(negedge i_wb_clk);
        chk("a5_prestop_vld", o_rx_valid, 1'b0);
      end
    join
    repeat (2) @(posedge i_wb_clk);
    model_commit(8'hA5, 1'b0);
    check_state("a5");
    chk("a5_busy", o_busy, 1'b0);
    do_rd();
    check_state("a5_rd");

    // Back-to-back frames without a read overrun the holding register.
    send_frame(8'h3C, 1'b1, BIT_NS);
    model_commit(8'h3C, 1'b0);
    send_frame(8'hC3, 1'b1, BIT_NS);
    model_commit(8'hC3, 1'b0);
    repeat (2) @(posedge i_wb_clk);
    check_state("b2b");
    do_rd();
    check_state("b2b_rd");

    send_frame(8'h3C, 1'b1, BIT_NS);
    model_commit(8'h3C, 1'b0);
    do_rd();
    send_frame(8'hC3, 1'b1, BIT_NS);
    model_commit(8'hC3, 1'b0);
    repeat (2) @(posedge i_wb_clk);
    check_state("b2b_rdmid");

    // Read in the commit cycle while a byte is held: new byte kept, no overrun.
    send_sync_rd(8'h5A);
    model_commit(8'h5A, 1'b1);
    check_state("rd_commit");
    do_rd();
    check_state("rd_commit_rd");

    // Short low glitch is rejected at mid-start.
    @(posedge i_wb_clk);
    #1 i_rx = 1'b0;
    repeat (4) @(posedge i_wb_clk);
    @(negedge i_wb_clk);
    chk("glitch_busy_hi", o_busy, 1'b1);
    @(posedge i_wb_clk);
    #1 i_rx = 1'b1;
    repeat (20) @(posedge i_wb_clk);
    check_state("glitch");
    chk("glitch_busy_lo", o_busy, 1'b0);

    // Bad stop bit followed by a long break: exactly one error, byte untouched.
    send_frame(8'h66, 1'b1, BIT_NS);
    model_commit(8'h66, 1'b0);
    send_frame(8'h55, 1'b0, BIT_NS);
    #(BIT_NS * 40.0);
    exp_ferr++;
    check_state("ferr_hold");
    chk("ferr_busy_hi", o_busy, 1'b1);
    i_rx = 1'b1;
    repeat (5) @(posedge i_wb_clk);
    check_state("ferr_rel");
    chk("ferr_busy_lo", o_busy, 1'b0);

    // Reset in the middle of bit 3 after building up valid and overrun.
    send_frame(8'h11, 1'b1, BIT_NS);
    model_commit(8'h11, 1'b0);
    send_frame(8'h22, 1'b1, BIT_NS);
    model_commit(8'h22, 1'b0);
    check_state("pre_rst");
    b = 8'($urandom_range(0, 255));
    i_rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 3; i++) begin
      i_rx = b[i];
      #(BIT_NS);
    end
    i_rx = b[3];
    #(BIT_NS / 2.0);
    i_wb_rst = 1'b1;
    #2;
    chk("rst_mid_dat", o_wb_dat, 8'h00);
    chk("rst_mid_vld", o_rx_valid, 1'b0);
    chk("rst_mid_ovr", o_overrun, 1'b0);
    chk("rst_mid_ferr", o_frame_err, 1'b0);
    chk("rst_mid_busy", o_busy, 1'b0);
    model_reset();
    i_rx = 1'b1;
    repeat (5) @(posedge i_wb_clk);
    #1 i_wb_rst = 1'b0;
    repeat (3) @(posedge i_wb_clk);
    check_state("post_rst");
    send_frame(8'h81, 1'b1, BIT_NS);
    repeat (2) @(posedge i_wb_clk);
    model_commit(8'h81, 1'b0);
    check_state("rst_81");
    do_rd();

    // Transmitter bit period skewed by up to +/-3%.
    for (int k = 0; k < 7; k++) begin
      for (int j = 0; j < 3; j++) begin
        b = 8'($urandom_range(0, 255));
        send_frame(b, 1'b1, BIT_NS * pf[k]);
        repeat (2) @(posedge i_wb_clk);
        model_commit(b, 1'b0);
        check_state("sweep");
        do_rd();
      end
    end
    check_state("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter clks_per_bit, default 104, meaning i_wb_clk cycles per serial bit (legal range 4..1023).
REQ-002 SHALL have parameter BITS, default 8, meaning data bits per frame (legal range 5..8).
REQ-003 SHALL have port i_wb_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_wb_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port i_rx, input, 1 bit: asynchronous serial line; idles high, frame is 8N1-style (start 0, BITS data bits LSB first, one stop 1).
REQ-006 SHALL have port i_rd, input, 1 bit: consumer acknowledge of the held byte.
REQ-007 SHALL have port o_wb_dat, output, BITS bits: last correctly framed received byte.
REQ-008 SHALL have port o_rx_valid, output, 1 bit: level, high while o_wb_dat holds an unread byte.
REQ-009 SHALL have port o_frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port o_overrun, output, 1 bit: sticky flag, set when a byte is overwritten unread.
REQ-011 SHALL have port o_busy, output, 1 bit: high in every state except IDLE.

Function
REQ-012 SHALL pass i_rx through a 2-flop synchronizer; all internal logic uses the synchronized value rx_s (2-cycle input latency).
REQ-013 SHALL implement states IDLE, START, DATA, STOP, BREAK with a bit-period counter of ceil(log2(clks_per_bit)) bits and a bit index of ceil(log2(BITS)) bits.
REQ-014 IDLE: counter and index held at 0; rx_s = 0 -> START.
REQ-015 START: count up to (clks_per_bit/2)-1 (integer division), then sample rx_s; 0 -> DATA with counter cleared; 1 -> glitch, back to IDLE, no outputs change.
REQ-016 DATA: when the counter reaches clks_per_bit-1, sample rx_s into shift-register bit [index], clear counter, increment index; after bit BITS-1 is sampled -> STOP.
REQ-017 STOP: when the counter reaches clks_per_bit-1, sample rx_s; 1 -> commit byte (REQ-019) and go to IDLE in the same cycle; 0 -> pulse o_frame_err for one cycle, discard byte, go to BREAK.
REQ-018 BREAK: remain until rx_s = 1, then go to IDLE; a low line never produces further frame errors or bytes.
REQ-019 Commit: load o_wb_dat and set o_rx_valid next cycle; if o_rx_valid was already 1 and i_rd is not asserted in the commit cycle, also set o_overrun (new data overwrites old).
REQ-020 i_rd with o_rx_valid = 1 SHALL clear o_rx_valid and o_overrun next cycle; i_rd with o_rx_valid = 0 has no effect.
REQ-021 Commit and i_rd in the same cycle: o_rx_valid stays 1 holding the new byte; o_overrun not set.
REQ-022 o_wb_dat SHALL change only on commit; frame errors and glitches leave it unchanged.
REQ-023 Back-to-back frames SHALL be received with zero idle bits between stop and next start.
REQ-024 Undefined state encodings SHALL return to IDLE on the next clock.

Reset
REQ-025 Asserting i_wb_rst SHALL immediately force: state IDLE, counter 0, index 0, synchronizer flops 1, shift register 0, o_wb_dat 0, o_rx_valid 0, o_frame_err 0, o_overrun 0, o_busy 0.
REQ-026 Reset mid-frame SHALL abandon the frame; after release, receiver waits in IDLE for the next falling edge (a line still low re-enters START).

Verification (clks_per_bit = 16, BITS = 8 unless stated)
REQ-027 Send 0xA5 with correct framing -> o_rx_valid rises 1 cycle after the mid-stop sample, o_wb_dat = 0xA5, o_frame_err and o_overrun stay 0; i_rd -> o_rx_valid 0 next cycle.
REQ-028 Send 0x3C then 0xC3 back-to-back, no i_rd -> o_wb_dat = 0xC3, o_rx_valid 1, o_overrun 1; repeat with i_rd pulsed between -> o_overrun 0.
REQ-029 Send 0x55 with stop bit 0, hold line low 40 bit-times, then release -> exactly one o_frame_err pulse, o_wb_dat unchanged, o_busy 1 until line high, then 0.
REQ-030 Drive i_rx low for 5 cycles then high -> start rejected, o_busy returns 0, no valid, no error.
REQ-031 Assert i_wb_rst during bit 3 of a frame, release, send 0x81 -> all outputs 0 during reset, then o_wb_dat = 0x81 correctly received.
REQ-032 Sweep transmitter bit period at clks_per_bit +/-3% with random bytes -> all bytes received correctly, no errors.
